// File: rtl/bpu_pkg.sv
// bpu_pkg: opcode/funct3 constants, two-bit counter states and saturating update helper.
package bpu_pkg;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_state_t;
    function automatic cnt_state_t sat_update(input cnt_state_t c, input logic taken);
        return taken ? (c == ST ? ST : cnt_state_t'(c + 2'd1))
                     : (c == SNT ? SNT : cnt_state_t'(c - 2'd1));
    endfunction
endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: combinational branch/jump outcome for the execute stage.
module branch_resolve
    import bpu_pkg::*;
(
    input  logic       valid_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       alu_lsb_i,
    output logic       pcsrc_o,
    output logic       is_branch_o,
    output logic       upd_o,
    output logic       jump_o
);
    logic legal, cond;
    always_comb begin
        legal       = funct3_i inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
        // funct3[0] inverts the sense; funct3[2] picks the slt result over the zero flag
        cond        = funct3_i[2] ? (alu_lsb_i ^ funct3_i[0]) : (zero_i ^ funct3_i[0]);
        is_branch_o = valid_i && op_i == OP_BRANCH;
        upd_o       = is_branch_o && legal;
        jump_o      = valid_i && (op_i == OP_JAL || op_i == OP_JALR);
        pcsrc_o     = jump_o || (upd_o && cond);
    end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: bimodal BHT predictor with execute-stage resolution and statistics.
// Optional gshare indexing is enabled with the macro BPU_GSHARE_EN.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pc_f,
    output logic             pred_taken_f,
    input  logic             valid_e,
    input  logic [6:0]       op_e,
    input  logic [2:0]       funct3_e,
    input  logic             zero_e,
    input  logic             alu_lsb_e,
    input  logic [XLEN-1:0]  pc_e,
    input  logic             pred_taken_e,
    output logic             pcsrc_e,
    output logic             mispredict_e,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispred
);
    localparam int N = 1 << IDX_W;
    cnt_state_t       bht_q [N];
    cnt_state_t       upd_cnt_d;
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d, cnt_mispred_q, cnt_mispred_d;
    logic             is_branch, upd, jump;
    logic             unused_pc_bits;

    branch_resolve u_resolve (
        .valid_i     (valid_e),
        .op_i        (op_e),
        .funct3_i    (funct3_e),
        .zero_i      (zero_e),
        .alu_lsb_i   (alu_lsb_e),
        .pcsrc_o     (pcsrc_e),
        .is_branch_o (is_branch),
        .upd_o       (upd),
        .jump_o      (jump)
    );

`ifdef BPU_GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;
    assign ghr_d  = upd ? ((ghr_q << 1) | IDX_W'(pcsrc_e)) : ghr_q;
    assign lk_idx = pc_f[IDX_W+1:2] ^ ghr_q;
    assign up_idx = pc_e[IDX_W+1:2] ^ ghr_q;
    always_ff @(posedge clk) ghr_q <= !rst_n ? '0 : ghr_d;
`else
    assign lk_idx = pc_f[IDX_W+1:2];
    assign up_idx = pc_e[IDX_W+1:2];
`endif

    assign unused_pc_bits = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0], pc_e[XLEN-1:IDX_W+2], pc_e[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not bypassed
    assign pred_taken_f  = bht_q[lk_idx][1];
    assign upd_cnt_d     = sat_update(bht_q[up_idx], pcsrc_e);
    assign mispredict_e  = jump ? 1'b1 : (is_branch ? (pcsrc_e != pred_taken_e) : 1'b0);
    assign cnt_branch_d  = cnt_branch_q + CNT_W'(upd);
    assign cnt_mispred_d = cnt_mispred_q + CNT_W'(mispredict_e);
    assign cnt_branch    = cnt_branch_q;
    assign cnt_mispred   = cnt_mispred_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) bht_q[i] <= WNT;
            cnt_branch_q  <= '0;
            cnt_mispred_q <= '0;
        end else begin
            if (upd) bht_q[up_idx] <= upd_cnt_d;
            cnt_branch_q  <= cnt_branch_d;
            cnt_mispred_q <= cnt_mispred_d;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed self-checking bench for branch_predict_unit.
module tb_branch_predict_unit;
    localparam int XLEN = 32, IDX_W = 6, CNT_W = 4;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [XLEN-1:0]  pc_f, pc_e;
    logic             pred_taken_f, valid_e, zero_e, alu_lsb_e, pred_taken_e;
    logic [6:0]       op_e;
    logic [2:0]       funct3_e;
    logic             pcsrc_e, mispredict_e;
    logic [CNT_W-1:0] cnt_branch, cnt_mispred;
    int tests = 0, fails = 0;

    branch_predict_unit #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
        .valid_e(valid_e), .op_e(op_e), .funct3_e(funct3_e), .zero_e(zero_e),
        .alu_lsb_e(alu_lsb_e), .pc_e(pc_e), .pred_taken_e(pred_taken_e),
        .pcsrc_e(pcsrc_e), .mispredict_e(mispredict_e),
        .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic z, input logic l, input logic [31:0] pc, input logic pt);
        valid_e = v; op_e = op; funct3_e = f3; zero_e = z; alu_lsb_e = l; pc_e = pc; pred_taken_e = pt;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pc_f = 32'h100;
        ex(0, 7'h00, 3'b000, 0, 0, 32'h0, 0);
        tick(); tick();
        // Resolution table checked while reset holds the state
        ex(1, 7'b1100011, 3'b001, 0, 0, 32'h100, 0); chk("bne_ne", pcsrc_e, 1);
        ex(1, 7'b1100011, 3'b001, 1, 0, 32'h100, 0); chk("bne_eq", pcsrc_e, 0);
        ex(1, 7'b1100011, 3'b100, 0, 1, 32'h100, 0); chk("blt_t", pcsrc_e, 1);
        ex(1, 7'b1100011, 3'b110, 0, 0, 32'h100, 0); chk("bltu_nt", pcsrc_e, 0);
        ex(1, 7'b1100011, 3'b101, 0, 0, 32'h100, 0); chk("bge_t", pcsrc_e, 1);
        ex(1, 7'b1100111, 3'b000, 0, 0, 32'h100, 0); chk("jalr", pcsrc_e, 1);
        ex(0, 7'b1100011, 3'b000, 1, 0, 32'h100, 0); chk("invalid_beq", pcsrc_e, 0);
        chk("invalid_mp", mispredict_e, 0);
        tick();
        rst_n = 1'b1; ex(0, 7'h00, 3'b000, 0, 0, 32'h0, 0);
        chk("rst_pred", pred_taken_f, 0);
        chk("rst_cntb", cnt_branch, 0);
        chk("rst_cntm", cnt_mispred, 0);
        // Three taken beq at 0x100, pred_taken_e tracking fetch prediction
        ex(1, 7'b1100011, 3'b000, 1, 0, 32'h100, pred_taken_f);
        chk("beq1_pcsrc", pcsrc_e, 1); chk("beq1_mp", mispredict_e, 1);
        tick(); chk("beq1_pred", pred_taken_f, 1);
        ex(1, 7'b1100011, 3'b000, 1, 0, 32'h100, pred_taken_f);
        chk("beq2_mp", mispredict_e, 0);
        tick();
        ex(1, 7'b1100011, 3'b000, 1, 0, 32'h100, pred_taken_f);
        chk("beq3_mp", mispredict_e, 0);
        tick();
        chk("beq3_pred", pred_taken_f, 1); chk("beq_cntb", cnt_branch, 3); chk("beq_cntm", cnt_mispred, 1);
        // bgeu not taken twice: ST -> WT -> WNT
        ex(1, 7'b1100011, 3'b111, 0, 1, 32'h100, 1);
        chk("bgeu_pcsrc", pcsrc_e, 0); chk("bgeu_mp", mispredict_e, 1);
        tick(); chk("bgeu1_pred", pred_taken_f, 1); chk("bgeu1_cntm", cnt_mispred, 2);
        ex(1, 7'b1100011, 3'b111, 0, 1, 32'h100, 1);
        tick(); chk("bgeu2_pred", pred_taken_f, 0); chk("bgeu2_cntm", cnt_mispred, 3);
        // JAL: redirect + flush, no table or branch-count change
        ex(1, 7'b1101111, 3'b000, 0, 0, 32'h100, 0);
        chk("jal_pcsrc", pcsrc_e, 1); chk("jal_mp", mispredict_e, 1);
        tick(); chk("jal_pred", pred_taken_f, 0); chk("jal_cntb", cnt_branch, 5); chk("jal_cntm", cnt_mispred, 4);
        // Reserved funct3 010 branch: no redirect, no update
        ex(1, 7'b1100011, 3'b010, 1, 1, 32'h100, 0);
        chk("f010_pcsrc", pcsrc_e, 0); chk("f010_mp", mispredict_e, 0);
        tick(); chk("f010_pred", pred_taken_f, 0); chk("f010_cntb", cnt_branch, 5);
        // Same-index lookup and update at 0x104 (idx 1) from WNT
        pc_f = 32'h104;
        ex(1, 7'b1100011, 3'b000, 1, 0, 32'h104, 0);
        chk("same_pre", pred_taken_f, 0);
        tick(); ex(0, 7'h00, 3'b000, 0, 0, 32'h0, 0);
        chk("same_post", pred_taken_f, 1); chk("same_cntb", cnt_branch, 6); chk("same_cntm", cnt_mispred, 5);
        // Drive cnt_branch to 2^CNT_W-1 with correctly predicted not-taken branches at 0x108
        for (int i = 0; i < 9; i++) begin
            ex(1, 7'b1100011, 3'b000, 0, 0, 32'h108, 0);
            tick();
        end
        chk("pre_wrap", cnt_branch, 15); chk("pre_wrap_m", cnt_mispred, 5);
        ex(1, 7'b1100011, 3'b000, 0, 0, 32'h108, 0);
        tick(); chk("wrap", cnt_branch, 0);
        // Mid-stream reset with a coincident taken update at 0x104 (WT) that must be discarded
        ex(0, 7'h00, 3'b000, 0, 0, 32'h0, 0);
        chk("pre_rst_pred", pred_taken_f, 1);
        rst_n = 1'b0;
        ex(1, 7'b1100011, 3'b000, 1, 0, 32'h104, 0);
        tick();
        chk("mid_rst_pred", pred_taken_f, 0); chk("mid_rst_cntb", cnt_branch, 0); chk("mid_rst_cntm", cnt_mispred, 0);
        rst_n = 1'b1; ex(0, 7'h00, 3'b000, 0, 0, 32'h0, 0);
        tick();
        chk("post_rst_pred", pred_taken_f, 0);
        pc_f = 32'h100; #1;
        chk("post_rst_pred100", pred_taken_f, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
